// File: rtl/fifo_stream_adapter.sv
// Read-side adapter for sync_fifo: absorbs the one-cycle SRAM read latency with a
// two-entry buffer and presents the words as a valid/ready stream.
module fifo_stream_adapter #(
    parameter int FIFO_PTR   = 10,
    parameter int FIFO_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    input  logic [FIFO_WIDTH-1:0] fifo_read_data,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_count
);

    if (FIFO_PTR < 1 || FIFO_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("fifo_stream_adapter: all widths must be at least 1");
    end

    logic                  vld_p1;
    logic [FIFO_WIDTH-1:0] buf_p2 [2];
    logic [1:0]            cnt_p2;
    logic                  head_p2;
    logic                  tail_p2;
    logic [CNT_WIDTH-1:0]  word_count_q;
    logic                  pop;
    logic [2:0]            occupancy;

    assign m_valid    = (cnt_p2 != 2'd0);
    assign m_data     = buf_p2[head_p2];
    assign pop        = m_valid & m_ready;
    assign word_count = word_count_q;

    // Entries held after this edge if no new read is issued; a pop implies cnt_p2 >= 1.
    assign occupancy    = {1'b0, cnt_p2} + {2'b00, vld_p1} - {2'b00, pop};
    assign fifo_read_en = ~fifo_empty & ~flush & ~rst_n & (occupancy <= 3'd1);

    // Stage p0 -> p1: the read strobe becomes the valid of the returning word.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= fifo_read_en;
        end
    end

    // Stage p1 -> p2: capture into the circular output buffer.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            buf_p2[0] <= '0;
            buf_p2[1] <= '0;
            cnt_p2    <= 2'd0;
            head_p2   <= 1'b0;
            tail_p2   <= 1'b0;
        end else if (flush) begin
            cnt_p2  <= 2'd0;
            head_p2 <= 1'b0;
            tail_p2 <= 1'b0;
        end else begin
            if (vld_p1) begin
                buf_p2[tail_p2] <= fifo_read_data;
                tail_p2         <= ~tail_p2;
            end
            if (pop) begin
                head_p2 <= ~head_p2;
            end
            cnt_p2 <= cnt_p2 + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            word_count_q <= '0;
        end else if (pop) begin
            word_count_q <= word_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: a queue-based FIFO model feeds the DUT and a
// scoreboard of words taken from the FIFO checks order, loss and the delivered count.
module tb_fifo_stream_adapter;

    localparam int FW = 32;
    localparam int CW = 8;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_read_en;
    logic [FW-1:0] fifo_read_data = '0;
    logic          flush = 1'b0;
    logic          m_valid;
    logic [FW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [CW-1:0] word_count;

    logic          push_req = 1'b0;
    logic [FW-1:0] push_data = '0;
    logic [FW-1:0] fifo_q[$];
    logic [FW-1:0] taken[$];
    logic [CW-1:0] exp_cnt = '0;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    fifo_stream_adapter #(.FIFO_PTR(PW), .FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en),
        .fifo_read_data(fifo_read_data), .flush(flush), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .word_count(word_count)
    );

    // FIFO model: registered empty flag, read data one cycle after the strobe
    always @(posedge clk) begin
        if (fifo_read_en) begin
            n_cmp++;
            if (fifo_empty || fifo_q.size() == 0) begin
                n_err++;
                $display("FAIL read_while_empty: read_en=1 with empty=%b size=%0d (required no read)",
                         fifo_empty, fifo_q.size());
            end else begin
                fifo_read_data <= fifo_q[0];
                taken.push_back(fifo_q[0]);
                void'(fifo_q.pop_front());
            end
        end
        if (push_req) fifo_q.push_back(push_data);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard: words taken from the FIFO must leave in order, at most two outstanding
    always @(negedge clk) begin
        if (rst_n) begin
            taken.delete();
            exp_cnt = '0;
        end else begin
            n_cmp++;
            if (word_count !== exp_cnt) begin
                n_err++;
                $display("FAIL sb_word_count: got %0d required %0d", word_count, exp_cnt);
            end
            n_cmp++;
            if (taken.size() > 2) begin
                n_err++;
                $display("FAIL sb_outstanding: got %0d required <= 2", taken.size());
            end
            if (m_valid) begin
                n_cmp++;
                if (taken.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_spurious_valid: m_data=%h with no word outstanding", m_data);
                end else if (m_data !== taken[0]) begin
                    n_err++;
                    $display("FAIL sb_order: m_data got %h required %h", m_data, taken[0]);
                end
            end
            if (m_valid && m_ready) begin
                if (taken.size() != 0) void'(taken.pop_front());
                exp_cnt = exp_cnt + CW'(1);
            end
            if (flush) taken.delete();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        push_req = 1'b0;
        flush = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && taken.size() == 0 && !m_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_req = 1'b1;
            push_data = 32'h10 + k;
            tick();
        end
        push_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp += 4;
            if (fifo_read_en !== 1'b0) begin n_err++; $display("FAIL reset_read_en c%0d: got %b required 0", k, fifo_read_en); end
            if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid c%0d: got %b required 0", k, m_valid); end
            if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data c%0d: got %h required 0", k, m_data); end
            if (word_count !== '0) begin n_err++; $display("FAIL reset_word_count c%0d: got %0d required 0", k, word_count); end
            tick();
        end
        rst_n = 1'b0;
        drain(ok);
        n_cmp += 2;
        if (!ok) begin n_err++; $display("FAIL reset_drain: got timeout required drained"); end
        if (word_count !== 8'd3) begin n_err++; $display("FAIL reset_after_count: got %0d required 3", word_count); end
    endtask

    task automatic test_streaming();
        int rd_first = -1, rd_last = -1, rd_n = 0, v_first = -1, v_n = 0;
        bit v_ok = 1'b1;
        do_reset(1);
        m_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            push_req = (k < 4);
            push_data = 32'hA0 + k;
            @(negedge clk);
            if (fifo_read_en) begin
                if (rd_first < 0) rd_first = k;
                rd_last = k;
                rd_n++;
            end
            if (m_valid) begin
                if (v_first < 0) v_first = k;
                if (m_data !== 32'hA0 + v_n || k != v_first + v_n) v_ok = 1'b0;
                v_n++;
            end
            tick();
        end
        push_req = 1'b0;
        n_cmp += 6;
        if (rd_n != 4) begin n_err++; $display("FAIL stream_reads: got %0d required 4", rd_n); end
        if (rd_last - rd_first != 3) begin n_err++; $display("FAIL stream_read_span: got %0d required 3", rd_last - rd_first); end
        if (v_n != 4 || !v_ok) begin n_err++; $display("FAIL stream_words: got %0d ok=%b required 4 consecutive A0..A3", v_n, v_ok); end
        if (v_first != rd_first + 2) begin n_err++; $display("FAIL stream_latency: got %0d required %0d", v_first, rd_first + 2); end
        if (word_count !== 8'd4) begin n_err++; $display("FAIL stream_count: got %0d required 4", word_count); end
        if (fifo_q.size() != 0) begin n_err++; $display("FAIL stream_fifo_left: got %0d required 0", fifo_q.size()); end
    endtask

    task automatic test_backpressure();
        int rd_n = 0, got = 0;
        bit ord_ok = 1'b1;
        do_reset(1);
        m_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            push_req = (k < 8);
            push_data = 32'hA0 + k;
            @(negedge clk);
            if (fifo_read_en) rd_n++;
            if (k >= 4) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== 32'hA0) begin
                    n_err++;
                    $display("FAIL bp_hold c%0d: got valid=%b data=%h required 1/a0", k, m_valid, m_data);
                end
            end
            tick();
        end
        push_req = 1'b0;
        n_cmp += 2;
        if (rd_n != 2) begin n_err++; $display("FAIL bp_reads: got %0d required 2", rd_n); end
        if (fifo_q.size() != 6) begin n_err++; $display("FAIL bp_fifo_count: got %0d required 6", fifo_q.size()); end
        m_ready = 1'b1;
        for (int i = 0; i < 40 && got < 8; i++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                if (m_data !== 32'hA0 + got) ord_ok = 1'b0;
                got++;
            end
            tick();
        end
        n_cmp += 2;
        if (got != 8 || !ord_ok) begin n_err++; $display("FAIL bp_release: got %0d ok=%b required 8 in order", got, ord_ok); end
        if (word_count !== 8'd8) begin n_err++; $display("FAIL bp_count: got %0d required 8", word_count); end
    endtask

    task automatic test_alternating();
        logic [FW-1:0] sent[$];
        logic [FW-1:0] got[$];
        for (int k = 0; k < 120 && got.size() < 16; k++) begin
            push_req = (k % 2 == 0) && (sent.size() < 16);
            if (push_req) begin
                push_data = $urandom;
                sent.push_back(push_data);
            end
            m_ready = (k % 2 == 0);
            @(negedge clk);
            if (m_valid && m_ready) got.push_back(m_data);
            tick();
        end
        push_req = 1'b0;
        m_ready = 1'b1;
        n_cmp++;
        if (got.size() != 16) begin
            n_err++;
            $display("FAIL alt_count: got %0d required 16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (got[i] !== sent[i]) begin n_err++; $display("FAIL alt_word%0d: got %h required %h", i, got[i], sent[i]); end
            end
        end
    endtask

    task automatic test_flush();
        bit ok;
        drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL flush_pre_drain: got timeout required drained"); end
        m_ready = 1'b0;
        push_req = 1'b1; push_data = 32'hC0; tick();
        push_data = 32'hC1;
        @(negedge clk);
        n_cmp++;
        if (fifo_read_en !== 1'b1) begin n_err++; $display("FAIL flush_rd1: got %b required 1", fifo_read_en); end
        tick();
        push_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fifo_read_en !== 1'b1) begin n_err++; $display("FAIL flush_rd2: got %b required 1", fifo_read_en); end
        tick();
        flush = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (fifo_read_en !== 1'b0) begin n_err++; $display("FAIL flush_rd_cycle: got %b required 0", fifo_read_en); end
        if (m_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %b required 1", m_valid); end
        tick();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push_req = (k == 1);
            push_data = 32'hB0;
            @(negedge clk);
            n_cmp++;
            if (m_valid !== 1'b0) begin n_err++; $display("FAIL flush_post_valid c%0d: got %b required 0", k, m_valid); end
            tick();
        end
        push_req = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) break;
            tick();
        end
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 32'hB0) begin n_err++; $display("FAIL flush_next_word: got valid=%b data=%h required 1/b0", m_valid, m_data); end
        tick();
        // Flush in a cycle where a read would otherwise issue
        m_ready = 1'b0;
        push_req = 1'b1; push_data = 32'hE0; tick();
        push_data = 32'hE1;
        @(negedge clk);
        n_cmp++;
        if (fifo_read_en !== 1'b1) begin n_err++; $display("FAIL flush2_rd1: got %b required 1", fifo_read_en); end
        tick();
        push_data = 32'hE2;
        flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fifo_read_en !== 1'b0) begin n_err++; $display("FAIL flush2_suppress: got %b required 0", fifo_read_en); end
        tick();
        push_req = 1'b0;
        flush = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) break;
            tick();
        end
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 32'hE1) begin n_err++; $display("FAIL flush2_next_word: got valid=%b data=%h required 1/e1", m_valid, m_data); end
        tick();
        drain(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL flush2_drain: got timeout required drained"); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset(1);
        m_ready = 1'b1;
        for (int k = 0; k < 255; k++) begin
            push_req = 1'b1;
            push_data = $urandom;
            tick();
        end
        drain(ok);
        n_cmp += 2;
        if (!ok) begin n_err++; $display("FAIL wrap_drain: got timeout required drained"); end
        if (word_count !== 8'hFF) begin n_err++; $display("FAIL wrap_full: got %h required ff", word_count); end
        push_req = 1'b1;
        push_data = $urandom;
        tick();
        drain(ok);
        n_cmp++;
        if (word_count !== 8'h00) begin n_err++; $display("FAIL wrap_zero: got %h required 00", word_count); end
    endtask

    task automatic test_midreset();
        bit ok;
        bit quiet = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_req = 1'b1;
            push_data = $urandom;
            tick();
        end
        drain(ok);
        n_cmp++;
        if (word_count !== 8'd3) begin n_err++; $display("FAIL mid_pre_count: got %0d required 3", word_count); end
        m_ready = 1'b0;
        push_req = 1'b1; push_data = 32'hF0; tick();
        push_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fifo_read_en !== 1'b1) begin n_err++; $display("FAIL mid_read: got %b required 1", fifo_read_en); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fifo_read_en !== 1'b0) begin n_err++; $display("FAIL mid_rd_in_reset: got %b required 0", fifo_read_en); end
        tick();
        @(negedge clk);
        n_cmp += 3;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b required 0", m_valid); end
        if (m_data !== '0) begin n_err++; $display("FAIL mid_data: got %h required 0", m_data); end
        if (word_count !== '0) begin n_err++; $display("FAIL mid_count: got %0d required 0", word_count); end
        tick();
        rst_n = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m_valid) quiet = 1'b0;
            tick();
        end
        n_cmp += 2;
        if (!quiet) begin n_err++; $display("FAIL mid_dropped: got a delivered word required none"); end
        if (word_count !== '0) begin n_err++; $display("FAIL mid_post_count: got %0d required 0", word_count); end
    endtask

    task automatic test_random();
        bit ok;
        for (int k = 0; k < 400; k++) begin
            push_req = ($urandom_range(0, 1) == 1);
            push_data = $urandom;
            m_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        drain(ok);
        n_cmp += 2;
        if (!ok) begin n_err++; $display("FAIL rand_drain: got timeout required drained"); end
        if (word_count !== exp_cnt) begin n_err++; $display("FAIL rand_count: got %0d required %0d", word_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_alternating();
        test_flush();
        test_wrap();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
